// File: rtl/iic_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the I2C target: FSM state encoding, ACK/NACK line levels, small helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package iic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } state_t;

    // Open-drain line levels: ACK pulls SDA low, NACK leaves it released.
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;

    // General-call address 0 never matches, even if the own address were 0.
    function automatic logic addr_match(input logic [7:0] abyte, input logic [6:0] own);
        return (abyte[7:1] == own) && (abyte[7:1] != 7'd0);
    endfunction

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/iic_edge_detect.sv
`timescale 1ns/1ps
// SCL/SDA synchronizer, optional 3-sample majority filter (IIC_SLAVE_GLITCH_FILTER_EN), edge and START/STOP flags.
// Latency: SYNC_STAGES cycles to level, +2 with the filter; flags are combinational on the level and one delayed copy.
// Backpressure: none; the bus cannot be stalled.
module iic_edge_detect
    import iic_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic core_clk,
    input  logic arst_n,
    input  logic scl_in,
    input  logic sda_in,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_lvl;
    logic                   sda_lvl;
    logic                   scl_d;
    logic                   sda_d;

    // Reset to 1 so a released bus looks idle and produces no edges.
    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_in};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_in};
        end
    end

`ifdef IIC_SLAVE_GLITCH_FILTER_EN
    logic [1:0] scl_hist;
    logic [1:0] sda_hist;
    logic       scl_filt;
    logic       sda_filt;

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            scl_hist <= '1;
            sda_hist <= '1;
            scl_filt <= 1'b1;
            sda_filt <= 1'b1;
        end else begin
            scl_hist <= {scl_hist[0], scl_sync[SYNC_STAGES-1]};
            sda_hist <= {sda_hist[0], sda_sync[SYNC_STAGES-1]};
            scl_filt <= maj3(scl_sync[SYNC_STAGES-1], scl_hist[0], scl_hist[1]);
            sda_filt <= maj3(sda_sync[SYNC_STAGES-1], sda_hist[0], sda_hist[1]);
        end
    end

    assign scl_lvl = scl_filt;
    assign sda_lvl = sda_filt;
`else
    assign scl_lvl = scl_sync[SYNC_STAGES-1];
    assign sda_lvl = sda_sync[SYNC_STAGES-1];
`endif

    always_ff @(posedge core_clk or negedge arst_n) begin
        if (!arst_n) begin
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_d <= scl_lvl;
            sda_d <= sda_lvl;
        end
    end

    assign sda      = sda_lvl;
    assign scl_rise = scl_lvl & ~scl_d;
    assign scl_fall = ~scl_lvl & scl_d;
    assign start    = scl_lvl & scl_d & sda_d & ~sda_lvl;
    assign stop     = scl_lvl & scl_d & ~sda_d & sda_lvl;

endmodule

// File: rtl/iic_slave.sv
`timescale 1ns/1ps
// I2C target with 7-bit address, byte writes to o_R_byte and byte reads from i_tx_byte; filter via IIC_SLAVE_GLITCH_FILTER_EN.
// Latency: SDA drive changes a few i_clk after the synchronized SCL fall; o_rx_valid/o_tx_req are single-cycle pulses.
// Backpressure: none; no clock stretching, so i_tx_byte must be ready by the capture edge.
module iic_slave
    import iic_pkg::*;
#(
    parameter logic [6:0] ADDR        = 7'b1001111,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_SCL,
    inout  wire        io_SDA,
    input  logic [7:0] i_tx_byte,
    output logic [7:0] o_R_byte,
    output logic       o_rx_valid,
    output logic       o_tx_req,
    output logic       o_busy,
    output logic       o_rw
);

    logic   sda_lvl, scl_rise, scl_fall, start, stop;
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [7:0] shreg, shreg_nxt;
    logic [7:0] tx_sh, tx_sh_nxt;
    logic [7:0] rbyte_nxt;
    logic       sda_q, sda_q_nxt;
    logic       m_ack, m_ack_nxt;
    logic       rx_vld_nxt, tx_req_nxt, busy_nxt, rw_nxt;

    iic_edge_detect #(.SYNC_STAGES(SYNC_STAGES)) u_edge (
        .core_clk (i_clk),
        .arst_n   (i_rst),
        .scl_in   (i_SCL),
        .sda_in   (io_SDA),
        .sda      (sda_lvl),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    // STOP releases the line combinationally so the release lands in the detect cycle.
    assign io_SDA = (sda_q == ACK && !stop) ? 1'b0 : 1'bz;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= ST_IDLE;
            cnt        <= 4'd0;
            shreg      <= 8'h00;
            tx_sh      <= 8'h00;
            sda_q      <= NACK;
            m_ack      <= 1'b0;
            o_R_byte   <= 8'h00;
            o_rx_valid <= 1'b0;
            o_tx_req   <= 1'b0;
            o_busy     <= 1'b0;
            o_rw       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            shreg      <= shreg_nxt;
            tx_sh      <= tx_sh_nxt;
            sda_q      <= sda_q_nxt;
            m_ack      <= m_ack_nxt;
            o_R_byte   <= rbyte_nxt;
            o_rx_valid <= rx_vld_nxt;
            o_tx_req   <= tx_req_nxt;
            o_busy     <= busy_nxt;
            o_rw       <= rw_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        shreg_nxt  = shreg;
        tx_sh_nxt  = tx_sh;
        sda_q_nxt  = sda_q;
        m_ack_nxt  = m_ack;
        rbyte_nxt  = o_R_byte;
        rx_vld_nxt = 1'b0;
        tx_req_nxt = 1'b0;
        busy_nxt   = o_busy;
        rw_nxt     = o_rw;
        if (stop) begin
            state_nxt = ST_IDLE;
            sda_q_nxt = NACK;
            busy_nxt  = 1'b0;
        end else if (start) begin
            state_nxt = ST_ADDR;
            cnt_nxt   = 4'd0;
            sda_q_nxt = NACK;
            busy_nxt  = 1'b0;
        end else if (scl_rise) begin
            cnt_nxt   = cnt + 4'd1;
            shreg_nxt = {shreg[6:0], sda_lvl};
            if (state == ST_RD_ACK)
                m_ack_nxt = (sda_lvl == ACK);
        end else if (scl_fall) begin
            case (state)
                ST_ADDR: if (cnt == 4'd8) begin
                    if (addr_match(shreg, ADDR)) begin
                        state_nxt = ST_ADDR_ACK;
                        sda_q_nxt = ACK;
                        busy_nxt  = 1'b1;
                        rw_nxt    = shreg[0];
                    end else begin
                        state_nxt = ST_IGNORE;
                    end
                end
                ST_ADDR_ACK: begin
                    cnt_nxt = 4'd0;
                    if (o_rw) begin
                        state_nxt  = ST_RD_DATA;
                        sda_q_nxt  = i_tx_byte[7];
                        tx_sh_nxt  = {i_tx_byte[6:0], 1'b0};
                        tx_req_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_WR_DATA;
                        sda_q_nxt = NACK;
                    end
                end
                ST_WR_DATA: if (cnt == 4'd8) begin
                    state_nxt  = ST_WR_ACK;
                    rbyte_nxt  = shreg;
                    rx_vld_nxt = 1'b1;
                    sda_q_nxt  = ACK;
                end
                ST_WR_ACK: begin
                    state_nxt = ST_WR_DATA;
                    cnt_nxt   = 4'd0;
                    sda_q_nxt = NACK;
                end
                ST_RD_DATA: begin
                    if (cnt == 4'd8) begin
                        state_nxt = ST_RD_ACK;
                        sda_q_nxt = NACK;
                    end else begin
                        sda_q_nxt = tx_sh[7];
                        tx_sh_nxt = {tx_sh[6:0], 1'b0};
                    end
                end
                ST_RD_ACK: begin
                    cnt_nxt = 4'd0;
                    if (m_ack) begin
                        state_nxt  = ST_RD_DATA;
                        sda_q_nxt  = i_tx_byte[7];
                        tx_sh_nxt  = {i_tx_byte[6:0], 1'b0};
                        tx_req_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_IGNORE;
                        sda_q_nxt = NACK;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
